// File: rtl/riscv_regfile_sb_if.sv
// Bus bundle for the scoreboarded register file: two write ports,
// the long-latency issue port, and NR read ports with busy flags.
interface riscv_regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NR   = 2
);
    logic               wa_en;
    logic [AW-1:0]      wa_addr;
    logic [XLEN-1:0]    wa_data;
    logic               wb_en;
    logic [AW-1:0]      wb_addr;
    logic [XLEN-1:0]    wb_data;
    logic               iss_en;
    logic [AW-1:0]      iss_addr;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*XLEN-1:0] rd_data;
    logic [NR-1:0]      rd_busy;
    logic [AW:0]        busy_cnt;
    logic               wr_conflict;

    modport master (
        output wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               iss_en, iss_addr, rd_addr,
        input  rd_data, rd_busy, busy_cnt, wr_conflict
    );

    modport slave (
        input  wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               iss_en, iss_addr, rd_addr,
        output rd_data, rd_busy, busy_cnt, wr_conflict
    );
endinterface

// File: rtl/riscv_regfile_sb.sv
// Register file with a busy-bit scoreboard for long-latency writebacks.
// x0 is hard-wired to zero. Port A (in-order writeback) wins over port B
// on a same-address collision. Reads bypass both write ports.
module riscv_regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NR   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_regfile_sb_if.slave    bus
);
    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [AW:0]     cnt;
    logic            conflict;

    logic wa_v;
    logic wb_v;
    logic iss_v;
    logic set_new;
    logic clr_old;

    // Qualify writes/issue; derive the net busy-count change for this cycle.
    always_comb begin
        wa_v    = bus.wa_en && (bus.wa_addr != '0);
        wb_v    = bus.wb_en && (bus.wb_addr != '0)
                  && !(wa_v && (bus.wa_addr == bus.wb_addr));
        iss_v   = bus.iss_en && (bus.iss_addr != '0);
        // A new issue only adds to the count if the bit was clear.
        set_new = iss_v && !busy[bus.iss_addr];
        // A writeback only removes from the count if the bit was set and a
        // same-cycle issue to the same register is not re-arming it.
        clr_old = bus.wb_en && busy[bus.wb_addr]
                  && !(iss_v && (bus.iss_addr == bus.wb_addr));
    end

    // Array update; port B is already masked on a collision with port A.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (wb_v) regs[bus.wb_addr] <= bus.wb_data;
            if (wa_v) regs[bus.wa_addr] <= bus.wa_data;
        end
    end

    // Scoreboard: writeback clears, issue sets; issue is applied last so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (bus.wb_en) busy[bus.wb_addr] <= 1'b0;
            if (iss_v)     busy[bus.iss_addr] <= 1'b1;
        end
    end

    // Busy count tracks popcount(busy) by applying the net delta.
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + (AW+1)'(set_new) - (AW+1)'(clr_old);
    end

    // One-cycle flag for an A/B write collision on a real register.
    always_ff @(posedge clk) begin
        if (rst) conflict <= 1'b0;
        else     conflict <= bus.wa_en && bus.wb_en && (bus.wa_addr != '0)
                             && (bus.wa_addr == bus.wb_addr);
    end

    assign bus.busy_cnt    = cnt;
    assign bus.wr_conflict = conflict;

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;

        assign a = bus.rd_addr[k*AW +: AW];

        // Read with bypass: port A, then port B, then the array; x0 reads 0.
        always_comb begin
            if (a == '0)
                d = '0;
            else if (bus.wa_en && (bus.wa_addr == a))
                d = bus.wa_data;
            else if (bus.wb_en && (bus.wb_addr == a))
                d = bus.wb_data;
            else
                d = regs[a];
        end

        // A writeback in flight this cycle already satisfies the dependency.
        always_comb begin
            b = busy[a] && !(bus.wb_en && (bus.wb_addr == a));
        end

        assign bus.rd_data[k*XLEN +: XLEN] = d;
        assign bus.rd_busy[k]              = b;
    end
endmodule
